// File: rtl/sec_countdown_pkg.sv
// -----------------------------------------------------------------------------
// sec_countdown_pkg
// Shared definitions for the two-digit BCD seconds countdown:
//   - state_t    : FSM state encoding (2 bits)
//   - BCD_W      : width of one BCD digit
//   - BCD_MAX    : largest legal BCD digit
//   - sat_bcd()  : clamps an arbitrary 4-bit value to a legal BCD digit
// -----------------------------------------------------------------------------
package sec_countdown_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Out-of-range load values (10..15) become 9 rather than wrapping.
  function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/sec_countdown_bcd_digit_dec.sv
// -----------------------------------------------------------------------------
// bcd_digit_dec
// Combinational single-digit BCD decrementer with borrow.
// Ports:
//   i_digit      in  4 : current BCD digit
//   i_dec_en     in  1 : decrement this digit
//   o_digit      out 4 : next digit (0 wraps to 9 when decrementing)
//   o_borrow_out out 1 : high when decrementing a digit that is 0
// -----------------------------------------------------------------------------
module bcd_digit_dec
  import sec_countdown_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_dec_en,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_borrow_out
);

  logic w_is_zero;

  assign w_is_zero    = (i_digit == '0);
  assign o_borrow_out = i_dec_en & w_is_zero;

  always_comb begin
    o_digit = i_digit;
    if (i_dec_en) begin
      o_digit = w_is_zero ? BCD_MAX : (i_digit - 4'd1);
    end
  end

endmodule

// File: rtl/sec_countdown.sv
// -----------------------------------------------------------------------------
// sec_countdown
// Two-digit BCD seconds countdown driven by the one-second pulse of secTimer.
// Owns the secTimer enable/clear, decrements on accepted pulses and flags
// timeout when the count reaches 00.
// Ports:
//   clk        in  1 : system clock
//   rst        in  1 : synchronous active-high reset
//   load       in  1 : load load_tens/load_ones (saturated to 9), go IDLE
//   load_tens  in  4 : BCD tens digit to load
//   load_ones  in  4 : BCD ones digit to load
//   start      in  1 : begin/resume counting
//   stop       in  1 : pause counting
//   sec_pulse  in  1 : one-cycle pulse from secTimer
//   tmr_en     out 1 : secTimer enable (high only in RUN)
//   tmr_clr    out 1 : one-cycle secTimer clear on entering RUN
//   tens       out 4 : current tens digit
//   ones       out 4 : current ones digit
//   running    out 1 : high while in RUN
//   timeout    out 1 : one-cycle pulse when the count reaches 00
// -----------------------------------------------------------------------------
module sec_countdown
  import sec_countdown_pkg::*;
#(
  parameter logic [3:0] START_TENS = 4'd3,
  parameter logic [3:0] START_ONES = 4'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  input  logic             start,
  input  logic             stop,
  input  logic             sec_pulse,
  output logic             tmr_en,
  output logic             tmr_clr,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             running,
  output logic             timeout
);

  state_t           r_state;
  state_t           w_state_next;
  logic [BCD_W-1:0] r_tens, r_ones;
  logic [BCD_W-1:0] w_tens_next, w_ones_next;
  logic             r_tmr_clr, w_tmr_clr_next;
  logic             r_timeout, w_timeout_next;
  logic             r_running;

  logic             w_count_zero;
  logic             w_count_one;
  logic             w_dec;

  // Digit chain: index 0 = ones, index 1 = tens; borrow ripples upward.
  logic [BCD_W-1:0] w_digit_cur [2];
  logic [BCD_W-1:0] w_digit_dec [2];
  logic [2:0]       w_dec_chain;

  assign w_digit_cur[0] = r_ones;
  assign w_digit_cur[1] = r_tens;
  assign w_dec_chain[0] = w_dec;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      bcd_digit_dec u_dec (
        .i_digit      (w_digit_cur[gi]),
        .i_dec_en     (w_dec_chain[gi]),
        .o_digit      (w_digit_dec[gi]),
        .o_borrow_out (w_dec_chain[gi+1])
      );
    end
  endgenerate

  assign w_count_zero = (r_tens == '0) && (r_ones == '0);
  assign w_count_one  = (r_tens == '0) && (r_ones == 4'd1);

  // A pulse decrements only in RUN when nothing of higher priority is
  // present; start is ignored in RUN so it does not mask the pulse.
  // The zero guard keeps the count from ever wrapping below 00.
  assign w_dec = (r_state == ST_RUN) && sec_pulse && !load && !stop && !w_count_zero;

  always_comb begin
    w_state_next   = r_state;
    w_tens_next    = r_tens;
    w_ones_next    = r_ones;
    w_tmr_clr_next = 1'b0;
    w_timeout_next = 1'b0;

    if (load) begin
      w_state_next = ST_IDLE;
      w_tens_next  = sat_bcd(load_tens);
      w_ones_next  = sat_bcd(load_ones);
    end else begin
      unique case (r_state)
        ST_IDLE, ST_PAUSE: begin
          if (start && !stop) begin
            if (w_count_zero) begin
              w_state_next   = ST_DONE;
              w_timeout_next = 1'b1;
            end else begin
              w_state_next   = ST_RUN;
              w_tmr_clr_next = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_next = ST_PAUSE;
          end else if (w_dec) begin
            w_tens_next = w_digit_dec[1];
            w_ones_next = w_digit_dec[0];
            if (w_count_one) begin
              w_state_next   = ST_DONE;
              w_timeout_next = 1'b1;
            end
          end
        end
        ST_DONE: begin
          w_state_next = ST_DONE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tens    <= START_TENS;
      r_ones    <= START_ONES;
      r_tmr_clr <= 1'b0;
      r_timeout <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tens    <= w_tens_next;
      r_ones    <= w_ones_next;
      r_tmr_clr <= w_tmr_clr_next;
      r_timeout <= w_timeout_next;
      r_running <= (w_state_next == ST_RUN);
    end
  end

  assign tens    = r_tens;
  assign ones    = r_ones;
  assign running = r_running;
  assign tmr_en  = r_running;
  assign tmr_clr = r_tmr_clr;
  assign timeout = r_timeout;

endmodule

// File: doc/sec_countdown.md
# sec_countdown

Two-digit BCD seconds countdown that consumes the one-second pulse produced by `secTimer`. It owns the `secTimer` enable and clear, decrements on each accepted pulse, and flags timeout at 00. The block sits between the seconds timer and the seven-segment display/game-control logic.

## Interface

Parameters:
- `START_TENS`, default 4'd3: tens digit loaded at reset; BCD value 0–9.
- `START_ONES`, default 4'd0: ones digit loaded at reset; BCD value 0–9.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: load `load_tens`/`load_ones` into the count.
- `load_tens` in 4: BCD tens digit to load.
- `load_ones` in 4: BCD ones digit to load.
- `start` in 1: begin or resume the countdown.
- `stop` in 1: pause the countdown.
- `sec_pulse` in 1: one-cycle pulse from `secTimer`.
- `tmr_en` out 1: enable for `secTimer`.
- `tmr_clr` out 1: one-cycle clear for `secTimer`, so the next pulse arrives a full second later.
- `tens` out 4: current tens digit (BCD).
- `ones` out 4: current ones digit (BCD).
- `running` out 1: high while in RUN.
- `timeout` out 1: one-cycle pulse when the count reaches 00.

## Operation

- States:
  - IDLE: loaded, not counting.
  - RUN: counting down.
  - PAUSE: halted mid-count.
  - DONE: count is 00.
- Priority of inputs within a cycle: `rst` > `load` > `stop` > `start` > `sec_pulse`.
- `load` (any state):
  - Count is set to the load digits; state becomes IDLE.
  - A digit above 9 saturates to 9.
  - Any concurrent `start`, `stop` or `sec_pulse` is ignored.
- `start`:
  - From IDLE or PAUSE with count ≠ 00: go to RUN and pulse `tmr_clr` for one cycle.
  - From IDLE or PAUSE with count = 00: go to DONE and pulse `timeout`.
  - In RUN or DONE: ignored.
- `stop` in RUN: go to PAUSE; count is held. Ignored in all other states.
- `sec_pulse` in RUN: decrement the count.
  - Ones digit 0 wraps to 9 and borrows from tens.
  - Ones digit nonzero decrements by 1.
  - When the count goes 01→00: state becomes DONE and `timeout` pulses.
- `sec_pulse` outside RUN: ignored, no effect.
- `tmr_en` = 1 only in RUN (registered, equals `running`).
- Count never underflows. DONE holds 00 until `load` or `rst`.

## Timing

- All outputs are registered; there are no combinational input→output paths.
- Reset values:
  - state IDLE.
  - `tens`/`ones` = `START_TENS`/`START_ONES`.
  - `tmr_en`, `tmr_clr`, `running`, `timeout` = 0.
- `start` sampled at edge N → `running`/`tmr_en`/`tmr_clr` high after edge N. `tmr_clr` drops after edge N+1.
- `sec_pulse` sampled at edge N → new digits visible after edge N (1-cycle latency).
- `timeout` is high for exactly the cycle in which the digits first read 00.
- `stop` at edge N → `tmr_en` low after edge N. A `sec_pulse` in the same cycle is dropped, because `stop` wins.
- `sec_pulse` while `tmr_clr` is high is still honored; it was generated by the prior second.
- `rst` mid-count: the next cycle shows reset values, regardless of other inputs.
- Back-to-back `sec_pulse` on consecutive cycles each decrement; this is legal for accelerated simulation.

## Structure

- Shared package holds:
  - State encoding localparams: IDLE, RUN, PAUSE, DONE (2 bits).
  - BCD width (4).
  - BCD max digit (4'd9).
- Sub-module `bcd_digit_dec`, instantiated twice (ones, then tens via borrow chain):
  - Inputs: digit, `dec_en`.
  - Outputs: next digit, `borrow_out` (asserted when digit = 0 and `dec_en` = 1).
- Top level holds the FSM, saturating load, and output registers.

## Test plan

- Reset with defaults → `tens`=3, `ones`=0, all flags 0. `start` → `tmr_clr` for one cycle, `running`=1. One `sec_pulse` → 2/9.
- `load` 0/2, `start`, three `sec_pulse` → 0/1, then 0/0 with `timeout` high one cycle and state DONE. Third pulse → no change, no second `timeout`.
- In RUN at 1/5: `stop` together with `sec_pulse` → stays 1/5, `tmr_en`=0. Further `sec_pulse` ignored. `start` → `tmr_clr` pulse, next pulse → 1/4.
- `load` 12/10 (invalid) → digits 9/9. `load` asserted together with `start` → IDLE, `running`=0.
- `load` 0/0 then `start` → DONE with `timeout` one cycle later, `tmr_clr` never asserted.
- `rst` asserted in RUN at 2/0 during a `sec_pulse` → next cycle 3/0, IDLE, all flags 0.
